// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through/write-allocate data cache controller between the LSQ and memory.
// Optional statistics counters are enabled with `define DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int NUM_LINES    = 32,
    parameter int NUM_MEM_TAGS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  proc2dcache_command,
    input  logic [31:0] proc2dcache_addr,
    input  logic [63:0] proc2dcache_data,
    output logic [3:0]  dcache_response,
    output logic        dcache_hit,
    output logic [63:0] dcache_data_out,
    output logic [3:0]  dcache_tag,
    output logic [1:0]  dcache2mem_command,
    output logic [31:0] dcache2mem_addr,
    output logic [63:0] dcache2mem_data,
    input  logic [3:0]  mem2dcache_response,
    input  logic [63:0] mem2dcache_data,
    input  logic [3:0]  mem2dcache_tag
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
    output logic [31:0] stat_fills
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - 3 - IDX_W;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic {IDLE, ST_FETCH} state_t;

    logic [NUM_LINES-1:0]    r_valid;
    logic [TAG_W-1:0]        r_lineTag  [NUM_LINES];
    logic [63:0]             r_lineData [NUM_LINES];
    logic [NUM_MEM_TAGS-1:0] r_mtValid;
    logic [NUM_MEM_TAGS-1:0] r_mtFwd;
    logic [NUM_MEM_TAGS-1:0] r_mtNoInst;
    logic [IDX_W-1:0]        r_mtIdx    [NUM_MEM_TAGS];
    logic [TAG_W-1:0]        r_mtTag    [NUM_MEM_TAGS];
    state_t                  r_state;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [31:0]      w_lineAddr;
    logic [63:0]      w_line;
    logic [63:0]      w_mergedLine;
    logic             w_lineHit;
    logic             w_isLoad;
    logic             w_isStore;
    logic             w_loadHit;
    logic             w_loadMiss;
    logic             w_storeHit;
    logic             w_stMissIssue;
    logic             w_memAccept;
    logic             w_storeAccept;
    logic             w_recordEntry;
    logic             w_fillValid;
    logic             w_fillFwd;
    logic             w_fillInstall;
    logic [IDX_W-1:0] w_fillIdx;
    logic             w_hitOut;
    logic             w_unused;

    assign w_idx      = proc2dcache_addr[3+IDX_W-1:3];
    assign w_tag      = proc2dcache_addr[31:3+IDX_W];
    assign w_lineAddr = {proc2dcache_addr[31:3], 3'b000};
    assign w_line     = r_lineData[w_idx];
    assign w_unused   = ^{proc2dcache_data[63:32], proc2dcache_addr[1:0]};

    assign w_mergedLine = proc2dcache_addr[2] ? {proc2dcache_data[31:0], w_line[31:0]}
                                              : {w_line[63:32], proc2dcache_data[31:0]};

    assign w_lineHit     = r_valid[w_idx] && (r_lineTag[w_idx] == w_tag);
    assign w_isLoad      = reset && (proc2dcache_command == BUS_LOAD);
    assign w_isStore     = reset && (proc2dcache_command == BUS_STORE);
    assign w_loadHit     = w_isLoad && w_lineHit;
    assign w_loadMiss    = w_isLoad && !w_lineHit;
    assign w_storeHit    = w_isStore && w_lineHit;
    assign w_stMissIssue = w_isStore && !w_lineHit && (r_state == IDLE);
    assign w_memAccept   = (mem2dcache_response != 4'd0);
    assign w_storeAccept = w_storeHit && w_memAccept;
    assign w_recordEntry = (w_loadMiss || w_stMissIssue) && w_memAccept;

    // A fill loses its install if a store to the same index lands in the same cycle.
    assign w_fillValid   = reset && (mem2dcache_tag != 4'd0) && r_mtValid[mem2dcache_tag];
    assign w_fillIdx     = r_mtIdx[mem2dcache_tag];
    assign w_fillFwd     = w_fillValid && r_mtFwd[mem2dcache_tag];
    assign w_fillInstall = w_fillValid && !r_mtNoInst[mem2dcache_tag]
                           && !(w_storeAccept && (w_idx == w_fillIdx));
    assign w_hitOut      = w_loadHit && !w_fillFwd;

    always_comb begin
        dcache_response    = 4'd0;
        dcache_hit         = w_hitOut;
        dcache_data_out    = 64'd0;
        dcache_tag         = 4'd0;
        dcache2mem_command = BUS_NONE;
        dcache2mem_addr    = 32'd0;
        dcache2mem_data    = 64'd0;
        if (w_fillFwd) begin
            dcache_tag      = mem2dcache_tag;
            dcache_data_out = mem2dcache_data;
        end else if (w_loadHit) begin
            dcache_data_out = w_line;
        end
        if (w_loadMiss) begin
            dcache2mem_command = BUS_LOAD;
            dcache2mem_addr    = w_lineAddr;
            dcache_response    = mem2dcache_response;
        end else if (w_storeHit) begin
            dcache2mem_command = BUS_STORE;
            dcache2mem_addr    = w_lineAddr;
            dcache2mem_data    = w_mergedLine;
            dcache_response    = mem2dcache_response;
        end else if (w_stMissIssue) begin
            dcache2mem_command = BUS_LOAD;
            dcache2mem_addr    = w_lineAddr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= '0;
            r_mtValid  <= '0;
            r_mtFwd    <= '0;
            r_mtNoInst <= '0;
            r_state    <= IDLE;
        end else begin
            if (w_fillInstall) begin
                r_valid[w_fillIdx] <= 1'b1;
            end
            if (w_fillValid) begin
                r_mtValid[mem2dcache_tag] <= 1'b0;
            end
            // Stale-fill guard: pending fills for a just-stored index must not overwrite it.
            for (int i = 0; i < NUM_MEM_TAGS; i++) begin
                if (w_storeAccept && r_mtValid[i] && (r_mtIdx[i] == w_idx)) begin
                    r_mtNoInst[i] <= 1'b1;
                end
            end
            if (w_recordEntry) begin
                r_mtValid[mem2dcache_response]  <= 1'b1;
                r_mtFwd[mem2dcache_response]    <= w_loadMiss;
                r_mtNoInst[mem2dcache_response] <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_stMissIssue && w_memAccept) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_fillValid && !r_mtFwd[mem2dcache_tag]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line payloads and entry addresses are qualified by valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_fillInstall) begin
            r_lineTag[w_fillIdx]  <= r_mtTag[mem2dcache_tag];
            r_lineData[w_fillIdx] <= mem2dcache_data;
        end
        if (w_storeAccept) begin
            r_lineData[w_idx] <= w_mergedLine;
        end
        if (w_recordEntry) begin
            r_mtIdx[mem2dcache_response] <= w_idx;
            r_mtTag[mem2dcache_response] <= w_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_hits   <= 32'd0;
            stat_misses <= 32'd0;
            stat_fills  <= 32'd0;
        end else begin
            if (w_hitOut || w_storeAccept) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (w_recordEntry) begin
                stat_misses <= stat_misses + 32'd1;
            end
            if (w_fillInstall) begin
                stat_fills <= stat_fills + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: cold misses, fills, store allocate,
// stale-fill guard, busy memory, fill/hit collision and mid-operation reset.
module tb_dcache_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  proc2dcache_command;
    logic [31:0] proc2dcache_addr;
    logic [63:0] proc2dcache_data;
    logic [3:0]  dcache_response;
    logic        dcache_hit;
    logic [63:0] dcache_data_out;
    logic [3:0]  dcache_tag;
    logic [1:0]  dcache2mem_command;
    logic [31:0] dcache2mem_addr;
    logic [63:0] dcache2mem_data;
    logic [3:0]  mem2dcache_response;
    logic [63:0] mem2dcache_data;
    logic [3:0]  mem2dcache_tag;
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
    logic [31:0] stat_fills;
`endif

    int checkCount = 0;
    int errorCount = 0;

    localparam logic [1:0] NONE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    dcache_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .proc2dcache_command (proc2dcache_command),
        .proc2dcache_addr    (proc2dcache_addr),
        .proc2dcache_data    (proc2dcache_data),
        .dcache_response     (dcache_response),
        .dcache_hit          (dcache_hit),
        .dcache_data_out     (dcache_data_out),
        .dcache_tag          (dcache_tag),
        .dcache2mem_command  (dcache2mem_command),
        .dcache2mem_addr     (dcache2mem_addr),
        .dcache2mem_data     (dcache2mem_data),
        .mem2dcache_response (mem2dcache_response),
        .mem2dcache_data     (mem2dcache_data),
        .mem2dcache_tag      (mem2dcache_tag)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits           (stat_hits),
        .stat_misses         (stat_misses),
        .stat_fills          (stat_fills)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later, well away from posedge.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] addr,
                                 input logic [63:0] data, input logic [3:0] mresp,
                                 input logic [63:0] mdata, input logic [3:0] mtag);
        @(negedge clk);
        proc2dcache_command = cmd;
        proc2dcache_addr    = addr;
        proc2dcache_data    = data;
        mem2dcache_response = mresp;
        mem2dcache_data     = mdata;
        mem2dcache_tag      = mtag;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    initial begin
        reset = 1'b0;
        proc2dcache_command = NONE;
        proc2dcache_addr    = 32'd0;
        proc2dcache_data    = 64'd0;
        mem2dcache_response = 4'd0;
        mem2dcache_data     = 64'd0;
        mem2dcache_tag      = 4'd0;

        // Outputs stay quiet under reset even with a live command.
        applyStimulus(LOAD, 32'h100, 64'd0, 4'd3, 64'd0, 4'd0);
        checkOutput("rst_resp", 64'(dcache_response), 64'd0);
        checkOutput("rst_memcmd", 64'(dcache2mem_command), 64'd0);
        checkOutput("rst_hit", 64'(dcache_hit), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Cold load miss, forwarded fill, then hit on the other word.
        applyStimulus(LOAD, 32'h100, 64'd0, 4'd3, 64'd0, 4'd0);
        checkOutput("lm_resp", 64'(dcache_response), 64'd3);
        checkOutput("lm_hit", 64'(dcache_hit), 64'd0);
        checkOutput("lm_memcmd", 64'(dcache2mem_command), 64'(LOAD));
        checkOutput("lm_memaddr", 64'(dcache2mem_addr), 64'h100);
        applyStimulus(NONE, 32'h0, 64'd0, 4'd0, 64'hAABB_CCDD_1122_3344, 4'd3);
        checkOutput("fill_tag", 64'(dcache_tag), 64'd3);
        checkOutput("fill_data", dcache_data_out, 64'hAABB_CCDD_1122_3344);
        applyStimulus(LOAD, 32'h104, 64'd0, 4'd9, 64'd0, 4'd0);
        checkOutput("lh_hit", 64'(dcache_hit), 64'd1);
        checkOutput("lh_data", dcache_data_out, 64'hAABB_CCDD_1122_3344);
        checkOutput("lh_resp", 64'(dcache_response), 64'd0);
        checkOutput("lh_memcmd", 64'(dcache2mem_command), 64'(NONE));

        // Store miss: allocate fetch, hold further store misses, then retry hits.
        applyStimulus(STORE, 32'h108, 64'h55, 4'd5, 64'd0, 4'd0);
        checkOutput("sm_resp", 64'(dcache_response), 64'd0);
        checkOutput("sm_memcmd", 64'(dcache2mem_command), 64'(LOAD));
        checkOutput("sm_memaddr", 64'(dcache2mem_addr), 64'h108);
        applyStimulus(STORE, 32'h108, 64'h55, 4'd7, 64'd0, 4'd0);
        checkOutput("fetch_memcmd", 64'(dcache2mem_command), 64'(NONE));
        checkOutput("fetch_resp", 64'(dcache_response), 64'd0);
        applyStimulus(NONE, 32'h0, 64'd0, 4'd0, 64'h1111_2222_3333_4444, 4'd5);
        checkOutput("sfill_tag", 64'(dcache_tag), 64'd0);
        checkOutput("sfill_data", dcache_data_out, 64'd0);
        applyStimulus(STORE, 32'h108, 64'h55, 4'd6, 64'd0, 4'd0);
        checkOutput("sh_memcmd", 64'(dcache2mem_command), 64'(STORE));
        checkOutput("sh_memdata", dcache2mem_data, 64'h1111_2222_0000_0055);
        checkOutput("sh_resp", 64'(dcache_response), 64'd6);
        applyStimulus(LOAD, 32'h10C, 64'd0, 4'd0, 64'hDEAD, 4'd6);
        checkOutput("sh_lhit", 64'(dcache_hit), 64'd1);
        checkOutput("sh_ldata", dcache_data_out, 64'h1111_2222_0000_0055);
        checkOutput("stcomp_tag", 64'(dcache_tag), 64'd0);

        // Stale fill: store hit on index 0 while a fill for 0x200 is pending.
        applyStimulus(LOAD, 32'h200, 64'd0, 4'd2, 64'd0, 4'd0);
        checkOutput("st_lm_resp", 64'(dcache_response), 64'd2);
        applyStimulus(STORE, 32'h100, 64'h77, 4'd8, 64'd0, 4'd0);
        checkOutput("st_sh_resp", 64'(dcache_response), 64'd8);
        checkOutput("st_sh_data", dcache2mem_data, 64'hAABB_CCDD_0000_0077);
        applyStimulus(NONE, 32'h0, 64'd0, 4'd0, 64'h2222_2222_2222_2222, 4'd2);
        checkOutput("st_fill_tag", 64'(dcache_tag), 64'd2);
        checkOutput("st_fill_data", dcache_data_out, 64'h2222_2222_2222_2222);
        applyStimulus(LOAD, 32'h100, 64'd0, 4'd0, 64'd0, 4'd0);
        checkOutput("st_keep_hit", 64'(dcache_hit), 64'd1);
        checkOutput("st_keep_data", dcache_data_out, 64'hAABB_CCDD_0000_0077);

        // Busy memory on a load miss: nothing recorded, later fill on that tag ignored.
        applyStimulus(LOAD, 32'h200, 64'd0, 4'd0, 64'd0, 4'd0);
        checkOutput("busy_hit", 64'(dcache_hit), 64'd0);
        checkOutput("busy_resp", 64'(dcache_response), 64'd0);
        checkOutput("busy_memcmd", 64'(dcache2mem_command), 64'(LOAD));
        applyStimulus(NONE, 32'h0, 64'd0, 4'd0, 64'h3333, 4'd2);
        checkOutput("busy_fill_tag", 64'(dcache_tag), 64'd0);

        // Fill collides with a load hit: fill wins, hit retried next cycle.
        applyStimulus(LOAD, 32'h318, 64'd0, 4'd4, 64'd0, 4'd0);
        checkOutput("col_lm_resp", 64'(dcache_response), 64'd4);
        applyStimulus(LOAD, 32'h100, 64'd0, 4'd0, 64'h4444_5555_6666_7777, 4'd4);
        checkOutput("col_tag", 64'(dcache_tag), 64'd4);
        checkOutput("col_hit", 64'(dcache_hit), 64'd0);
        checkOutput("col_data", dcache_data_out, 64'h4444_5555_6666_7777);
        checkOutput("col_resp", 64'(dcache_response), 64'd0);
        applyStimulus(LOAD, 32'h100, 64'd0, 4'd0, 64'd0, 4'd0);
        checkOutput("col_rehit", 64'(dcache_hit), 64'd1);
        checkOutput("col_redata", dcache_data_out, 64'hAABB_CCDD_0000_0077);
        applyStimulus(LOAD, 32'h31C, 64'd0, 4'd0, 64'd0, 4'd0);
        checkOutput("col_inst_data", dcache_data_out, 64'h4444_5555_6666_7777);

        // Reset mid-operation with entry 6 pending and a store fetch in flight.
        applyStimulus(LOAD, 32'h400, 64'd0, 4'd6, 64'd0, 4'd0);
        checkOutput("mr_lm_resp", 64'(dcache_response), 64'd6);
        applyStimulus(STORE, 32'h508, 64'h1, 4'd7, 64'd0, 4'd0);
        checkOutput("mr_sm_memcmd", 64'(dcache2mem_command), 64'(LOAD));
        applyStimulus(LOAD, 32'h100, 64'd0, 4'd0, 64'd0, 4'd0);
        reset = 1'b0;
        #1;
        checkOutput("mr_rst_hit", 64'(dcache_hit), 64'd0);
        checkOutput("mr_rst_data", dcache_data_out, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(NONE, 32'h0, 64'd0, 4'd0, 64'h6666, 4'd6);
        checkOutput("mr_late_tag", 64'(dcache_tag), 64'd0);
        checkOutput("mr_late_data", dcache_data_out, 64'd0);
        applyStimulus(LOAD, 32'h100, 64'd0, 4'd0, 64'd0, 4'd0);
        checkOutput("mr_cold_hit", 64'(dcache_hit), 64'd0);
        applyStimulus(LOAD, 32'h400, 64'd0, 4'd0, 64'd0, 4'd0);
        checkOutput("mr_noinst_hit", 64'(dcache_hit), 64'd0);
        applyStimulus(STORE, 32'h508, 64'h1, 4'd0, 64'd0, 4'd0);
        checkOutput("mr_idle_memcmd", 64'(dcache2mem_command), 64'(LOAD));

        applyStimulus(NONE, 32'h0, 64'd0, 4'd0, 64'd0, 4'd0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
